// File: rtl/rtx_pkg.sv
// Shared ray-tracer types and width helpers.
// Provides the fixed-point vector type, pixel coordinate widths, counter
// width helpers and the dispatcher state encoding.
package rtx_pkg;

  localparam int FP_W = 16;
  typedef logic signed [FP_W-1:0] fp_t;

  typedef struct packed {
    fp_t x;
    fp_t y;
    fp_t z;
  } fp_vec3;

  localparam int PIX_H_W = 11;
  localparam int PIX_V_W = 10;

  // Bits needed to count every ray of a w x h frame, including the full count.
  function automatic int ray_cnt_w(input int w, input int h);
    return $clog2(w * h + 1);
  endfunction

  // Index width for an n-entry vector; a single entry still gets one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int RAY_CNT_W = ray_cnt_w(1280, 720);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARB,
    ST_WAIT,
    ST_DRAIN
  } disp_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: picks the first asserted request at or after ptr,
// wrapping at N. Purely combinational.
// Ports: req (N requests), ptr (search start), grant (one-hot), grant_idx.
module rr_arbiter
  import rtx_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx
);

  // One spare bit so ptr + offset cannot overflow before the wrap.
  localparam int SW = IW + 1;

  logic [SW-1:0] pos;
  logic          found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    pos       = '0;
    for (int i = 0; i < N; i++) begin
      pos = {1'b0, ptr} + SW'(i);
      if (pos >= SW'(N)) begin
        pos = pos - SW'(N);
      end
      if (!found && req[pos[IW-1:0]]) begin
        found                 = 1'b1;
        grant_idx             = pos[IW-1:0];
        grant[pos[IW-1:0]]    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ray_dispatcher.sv
// Frame scheduler: requests rays from one caster and hands each ray to an
// idle, ready tracer core chosen round-robin; tracks rays in flight and
// pulses frame_done once every ray of the frame is issued and retired.
// Ports: start_frame/frame_busy/frame_done frame control; core_ready,
// core_done per-core status; caster_new_ray/caster_* caster handshake;
// core_ray_valid one-hot select plus registered broadcast ray fields.
module ray_dispatcher
  import rtx_pkg::*;
#(
  parameter int NUM_CORES = 4,
  parameter int WIDTH     = 1280,
  parameter int HEIGHT    = 720
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_frame,
  input  logic [NUM_CORES-1:0] core_ready,
  input  logic [NUM_CORES-1:0] core_done,
  output logic                 caster_new_ray,
  input  logic                 caster_valid,
  input  fp_vec3               caster_origin,
  input  fp_vec3               caster_dir,
  input  logic [PIX_H_W-1:0]   caster_h,
  input  logic [PIX_V_W-1:0]   caster_v,
  output logic [NUM_CORES-1:0] core_ray_valid,
  output fp_vec3               ray_origin,
  output fp_vec3               ray_dir,
  output logic [PIX_H_W-1:0]   pixel_h,
  output logic [PIX_V_W-1:0]   pixel_v,
  output logic                 frame_busy,
  output logic                 frame_done
);

  localparam int TOTAL = WIDTH * HEIGHT;
  localparam int CNT_W = ray_cnt_w(WIDTH, HEIGHT);
  localparam int OUT_W = $clog2(NUM_CORES + 1);
  localparam int IDX_W = idx_w(NUM_CORES);

  disp_state_e           state_q, state_d;
  logic [CNT_W-1:0]      issued_q, issued_d;
  logic [OUT_W-1:0]      outstanding_q, outstanding_d;
  logic [NUM_CORES-1:0]  busy_q, busy_d;
  logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [NUM_CORES-1:0]  grant_q, grant_d;
  logic [NUM_CORES-1:0]  core_ray_valid_q, core_ray_valid_d;
  fp_vec3                ray_origin_q, ray_origin_d;
  fp_vec3                ray_dir_q, ray_dir_d;
  logic [PIX_H_W-1:0]    pixel_h_q, pixel_h_d;
  logic [PIX_V_W-1:0]    pixel_v_q, pixel_v_d;
  logic                  frame_busy_q, frame_busy_d;
  logic                  frame_done_q, frame_done_d;

  logic [NUM_CORES-1:0]  eligible;
  logic [NUM_CORES-1:0]  arb_grant;
  logic [IDX_W-1:0]      arb_idx;
  logic [NUM_CORES-1:0]  done_ok;
  logic [OUT_W-1:0]      done_cnt;
  logic                  dispatch;

  assign eligible = core_ready & ~busy_q;

  rr_arbiter #(
    .N  (NUM_CORES),
    .IW (IDX_W)
  ) u_rr_arbiter (
    .req       (eligible),
    .ptr       (rr_ptr_q),
    .grant     (arb_grant),
    .grant_idx (arb_idx)
  );

  always_comb begin
    state_d          = state_q;
    issued_d         = issued_q;
    rr_ptr_d         = rr_ptr_q;
    grant_d          = grant_q;
    core_ray_valid_d = '0;
    ray_origin_d     = ray_origin_q;
    ray_dir_d        = ray_dir_q;
    pixel_h_d        = pixel_h_q;
    pixel_v_d        = pixel_v_q;
    frame_busy_d     = frame_busy_q;
    frame_done_d     = 1'b0;
    caster_new_ray   = 1'b0;
    dispatch         = 1'b0;

    // Retirements are honoured only for cores actually holding a ray, and
    // never in IDLE, so stray pulses after a reset cannot corrupt counters.
    done_ok = (state_q != ST_IDLE) ? (core_done & busy_q) : '0;
    busy_d  = busy_q & ~done_ok;

    case (state_q)
      ST_IDLE: begin
        if (start_frame) begin
          state_d      = ST_ARB;
          frame_busy_d = 1'b1;
          issued_d     = '0;
        end
      end

      ST_ARB: begin
        if (issued_q == CNT_W'(TOTAL)) begin
          state_d = ST_DRAIN;
        end else if (eligible != '0) begin
          caster_new_ray = 1'b1;
          grant_d        = arb_grant;
          rr_ptr_d       = (arb_idx == IDX_W'(NUM_CORES - 1)) ? '0 : arb_idx + 1'b1;
          state_d        = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (caster_valid) begin
          dispatch         = 1'b1;
          ray_origin_d     = caster_origin;
          ray_dir_d        = caster_dir;
          pixel_h_d        = caster_h;
          pixel_v_d        = caster_v;
          core_ray_valid_d = grant_q;
          busy_d           = busy_d | grant_q;
          issued_d         = issued_q + 1'b1;
          state_d          = ST_ARB;
        end
      end

      ST_DRAIN: begin
        if (outstanding_q == '0) begin
          frame_done_d = 1'b1;
          frame_busy_d = 1'b0;
          state_d      = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Several cores may retire together; a dispatch and a retirement in the
    // same cycle cancel out.
    done_cnt = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      done_cnt = done_cnt + OUT_W'(done_ok[i]);
    end
    outstanding_d = outstanding_q + OUT_W'(dispatch) - done_cnt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= ST_IDLE;
      issued_q         <= '0;
      outstanding_q    <= '0;
      busy_q           <= '0;
      rr_ptr_q         <= '0;
      grant_q          <= '0;
      core_ray_valid_q <= '0;
      ray_origin_q     <= '0;
      ray_dir_q        <= '0;
      pixel_h_q        <= '0;
      pixel_v_q        <= '0;
      frame_busy_q     <= 1'b0;
      frame_done_q     <= 1'b0;
    end else begin
      state_q          <= state_d;
      issued_q         <= issued_d;
      outstanding_q    <= outstanding_d;
      busy_q           <= busy_d;
      rr_ptr_q         <= rr_ptr_d;
      grant_q          <= grant_d;
      core_ray_valid_q <= core_ray_valid_d;
      ray_origin_q     <= ray_origin_d;
      ray_dir_q        <= ray_dir_d;
      pixel_h_q        <= pixel_h_d;
      pixel_v_q        <= pixel_v_d;
      frame_busy_q     <= frame_busy_d;
      frame_done_q     <= frame_done_d;
    end
  end

  assign core_ray_valid = core_ray_valid_q;
  assign ray_origin     = ray_origin_q;
  assign ray_dir        = ray_dir_q;
  assign pixel_h        = pixel_h_q;
  assign pixel_v        = pixel_v_q;
  assign frame_busy     = frame_busy_q;
  assign frame_done     = frame_done_q;

  // A retirement from a core that holds no ray indicates a broken core.
  a_done_legal: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q != ST_IDLE) |-> ((core_done & ~busy_q) == '0));

endmodule
